// File: rtl/switch_pkg.sv
// Shared constants and helpers for the switch input conditioning stage.
// Provides default width, reset level, debounce window and counter sizing.
package switch_pkg;

   localparam int               SW_WIDTH               = 4;
   localparam logic [SW_WIDTH-1:0] SW_RESET_VAL        = 4'b1111;
   localparam int               SW_DEBOUNCE_20MS_50MHZ = 1_000_000;

   // Counter must reach n-1; never narrower than one bit.
   function automatic int sw_cnt_w(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/debounce_bit.sv
// One-bit synchroniser + stability counter + debounced flop (+ edge pulses under SWITCH_DEBOUNCE_EDGE_EN).
// Latency DEBOUNCE_CYCLES+2 clocks from first sample; no backpressure, level is accepted unconditionally.
module debounce_bit
   import switch_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = SW_DEBOUNCE_20MS_50MHZ,
   parameter logic RESET_VAL_BIT   = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic stable,
   output logic rise,
   output logic fall
);

   localparam int                CNT_W    = sw_cnt_w(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1;
   logic             s2;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1     <= RESET_VAL_BIT;
         s2     <= RESET_VAL_BIT;
         stable <= RESET_VAL_BIT;
         cnt    <= '0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         // Any return to the accepted level restarts the stability window.
         if (s2 == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            stable <= s2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

`ifdef SWITCH_DEBOUNCE_EDGE_EN
   logic accept;
   assign accept = (s2 != stable) && (cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         rise <= accept &  s2;
         fall <= accept & ~s2;
      end
   end
`else
   assign rise = 1'b0;
   assign fall = 1'b0;
`endif

endmodule

// File: rtl/switch_debounce.sv
// Debounces WIDTH raw switch pins into a clean sw_stable bus; rise/fall pulses need SWITCH_DEBOUNCE_EDGE_EN.
// Latency DEBOUNCE_CYCLES+2 clocks per bit; no backpressure, all bits run independently.
module switch_debounce
   import switch_pkg::*;
#(
   parameter int               WIDTH           = SW_WIDTH,
   parameter int               DEBOUNCE_CYCLES = SW_DEBOUNCE_20MS_50MHZ,
   parameter logic [WIDTH-1:0] RESET_VAL       = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_stable,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_VAL_BIT   (RESET_VAL[i])
      ) u_bit (
         .clk    (clk),
         .rst    (rst),
         .raw    (sw_raw[i]),
         .stable (sw_stable[i]),
         .rise   (sw_rise[i]),
         .fall   (sw_fall[i])
      );
   end

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce with DEBOUNCE_CYCLES=4: directed test-plan steps plus random bouncing,
// checked every cycle against a sliding-window reference of the sampled pin history.
module tb_switch_debounce;

   localparam int         W  = 4;
   localparam int         N  = 4;
   localparam logic [3:0] RV = 4'hF;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
   localparam bit EDGE_EN = 1'b1;
`else
   localparam bit EDGE_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] sw_raw = RV;
   logic [W-1:0] sw_stable, sw_rise, sw_fall;

   int tests = 0;
   int fails = 0;

   // Reference: history of pin values sampled at each edge (newest at the back).
   logic [W-1:0] hist[$];
   logic [W-1:0] m_stable = RV;
   logic [W-1:0] m_rise   = '0;
   logic [W-1:0] m_fall   = '0;

   switch_debounce #(
      .WIDTH           (W),
      .DEBOUNCE_CYCLES (N),
      .RESET_VAL       (RV)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sw_raw    (sw_raw),
      .sw_stable (sw_stable),
      .sw_rise   (sw_rise),
      .sw_fall   (sw_fall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // A level is accepted when the last N values seen after the two-flop delay all
   // differ from the current accepted level.
   task automatic model_edge(input logic r, input logic [W-1:0] pins);
      logic [W-1:0] nxt;
      if (r) begin
         foreach (hist[j]) hist[j] = RV;
         hist.push_back(RV);
         m_stable = RV;
         m_rise   = '0;
         m_fall   = '0;
      end else begin
         nxt = m_stable;
         for (int b = 0; b < W; b++) begin
            bit all_diff;
            all_diff = 1'b1;
            for (int j = 2; j <= N + 1; j++)
               if (hist[hist.size() - j][b] == m_stable[b]) all_diff = 1'b0;
            if (all_diff) nxt[b] = ~m_stable[b];
         end
         m_rise   = EDGE_EN ? (nxt & ~m_stable) : '0;
         m_fall   = EDGE_EN ? (~nxt & m_stable) : '0;
         m_stable = nxt;
         hist.push_back(pins);
      end
      while (hist.size() > N + 2) void'(hist.pop_front());
   endtask

   task automatic step(input logic [W-1:0] pins, input logic r);
      sw_raw = pins;
      rst    = r;
      @(posedge clk);
      model_edge(r, pins);
      #1;
      chk("stable", sw_stable, m_stable);
      chk("rise",   sw_rise,   m_rise);
      chk("fall",   sw_fall,   m_fall);
   endtask

   task automatic hold(input logic [W-1:0] pins, input int n);
      for (int c = 0; c < n; c++) step(pins, 1'b0);
   endtask

   initial begin
      int pulses;
      logic [W-1:0] pins;
      for (int j = 0; j < N + 2; j++) hist.push_back(RV);

      // Reset held three cycles, then idle with no pulses.
      for (int c = 0; c < 3; c++) step(RV, 1'b1);
      chk("reset_stable", sw_stable, 4'hF);
      hold(RV, 10);

      // Clean press of bit 1: unchanged through k+4, accepted at k+5.
      hold(4'hD, 5);
      chk("press_before", sw_stable, 4'hF);
      step(4'hD, 1'b0);
      chk("press_after", sw_stable, 4'hD);
      chk("press_fall", sw_fall, EDGE_EN ? 4'b0010 : 4'b0000);
      hold(4'hD, 3);
      hold(RV, 8);
      chk("release", sw_stable, 4'hF);

      // Bounce shorter than the window never gets accepted.
      pulses = 0;
      hold(4'hD, 3); hold(RV, 1); hold(4'hD, 2); hold(RV, 8);
      chk("bounce", sw_stable, 4'hF);

      // Two bits falling together, then rising together.
      hold(4'h6, 5);
      step(4'h6, 1'b0);
      chk("multi_fall_stable", sw_stable, 4'h6);
      chk("multi_fall_pulse", sw_fall, EDGE_EN ? 4'b1001 : 4'b0000);
      hold(4'h6, 3);
      hold(RV, 5);
      step(RV, 1'b0);
      chk("multi_rise_stable", sw_stable, 4'hF);
      chk("multi_rise_pulse", sw_rise, EDGE_EN ? 4'b1001 : 4'b0000);
      hold(RV, 4);

      // Reset mid-count: count discarded, accepted N+1 edges after first post-reset sample.
      hold(4'hB, 2);
      step(4'hB, 1'b1);
      chk("midreset_stable", sw_stable, 4'hF);
      hold(4'hB, 5);
      chk("midreset_before", sw_stable, 4'hF);
      step(4'hB, 1'b0);
      chk("midreset_after", sw_stable, 4'hB);
      hold(4'hB, 3);
      hold(RV, 8);

      // Random bouncing on all bits with occasional resets.
      pins = RV;
      for (int c = 0; c < 1500; c++) begin
         for (int b = 0; b < W; b++)
            if ($urandom_range(0, 5) == 0) pins[b] = ~pins[b];
         step(pins, ($urandom_range(0, 149) == 0));
         if (sw_rise != 0 || sw_fall != 0) pulses++;
      end
      hold(RV, 10);
      chk("final_idle", sw_stable, 4'hF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
